// File: rtl/vending_pkg.sv
// Coin codes and output-FSM state encoding shared by the coin acceptor
// and the vending FSM downstream of it.
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } out_state_t;

    function automatic logic [1:0] coin_code(input logic is10);
        return is10 ? COIN_10 : COIN_5;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: two-flop synchroniser, consecutive-sample
// debouncer and a registered rising-edge event (one pulse per coin).
module coin_debounce
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            // this differing sample is the DEBOUNCE_CYCLES-th in a row
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // level resets high so a sensor stuck high through reset never counts as a coin
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounced Rs5/Rs10 events -> coin FIFO -> one-cycle codes with idle gap.
// Define COIN_ACCEPTOR_TALLY_EN to add the tally5/tally10 emitted-coin counters.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          coin5_raw,
    input  logic                          coin10_raw,
    input  logic                          accept_en,
    output logic [1:0]                    in,
    output logic                          reject,
    output logic                          overflow,
`ifdef COIN_ACCEPTOR_TALLY_EN
    output logic [15:0]                   tally5,
    output logic [15:0]                   tally10,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int GW   = $clog2(GAP_CYCLES + 1);

    logic ev5, ev10;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (coin5_raw),
        .rise_o (ev5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (coin10_raw),
        .rise_o (ev10)
    );

    logic [FIFO_DEPTH-1:0] mem_q;
    logic [AW-1:0]         wr_q, rd_q;
    logic [CNTW-1:0]       count_q;
    logic                  reject_q, overflow_q;
    out_state_t            state_q;
    logic [1:0]            in_q;
    logic [GW-1:0]         gap_q;

    logic can_leave, pop, single, jam, full_after_pop, push, drop;

    // The last GAP cycle may pop directly so back-to-back coins are 1+GAP_CYCLES apart.
    always_comb begin
        can_leave      = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_q == '0));
        pop            = can_leave && (count_q != '0) && accept_en;
        single         = ev5 ^ ev10;
        jam            = ev5 & ev10;
        full_after_pop = (count_q == CNTW'(FIFO_DEPTH)) && !pop;
        push           = single && !full_after_pop;
        drop           = single && full_after_pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            reject_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= ev10;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            count_q    <= count_q + CNTW'(push) - CNTW'(pop);
            reject_q   <= jam | drop;
            overflow_q <= overflow_q | drop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            in_q    <= COIN_NONE;
            gap_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        in_q    <= coin_code(mem_q[rd_q]);
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    in_q    <= COIN_NONE;
                    gap_q   <= GW'(GAP_CYCLES - 1);
                    state_q <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        if (pop) begin
                            in_q    <= coin_code(mem_q[rd_q]);
                            state_q <= ST_EMIT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: begin
                    in_q    <= COIN_NONE;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [15:0] tally5_q, tally10_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tally5_q  <= '0;
            tally10_q <= '0;
        end else if (state_q == ST_EMIT) begin
            if (in_q == COIN_5) begin
                tally5_q <= tally5_q + 16'd1;
            end else if (in_q == COIN_10) begin
                tally10_q <= tally10_q + 16'd1;
            end
        end
    end

    assign tally5  = tally5_q;
    assign tally10 = tally10_q;
`endif

    assign in         = in_q;
    assign reject     = reject_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (DEBOUNCE_CYCLES=8, FIFO_DEPTH=4, GAP_CYCLES=1).
module tb_coin_acceptor;

    logic        clk = 1'b0;
    logic        rst;
    logic        coin5_raw;
    logic        coin10_raw;
    logic        accept_en;
    logic [1:0]  in_c;
    logic        reject;
    logic        overflow;
    logic [2:0]  fifo_count;
`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [15:0] tally5;
    logic [15:0] tally10;
`endif

    int n_checks = 0;
    int n_err    = 0;

    int         cyc_idx, cnt01, cnt10, n_rej, n_adj, first01;
    logic [1:0] prev_in;
    logic [1:0] codes[$];
    int         idxs[$];
    int         exp_codes[4] = '{1, 2, 1, 2};

    always #5 clk = ~clk;

    coin_acceptor dut (
        .clk        (clk),
        .rst        (rst),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
        .accept_en  (accept_en),
        .in         (in_c),
        .reject     (reject),
        .overflow   (overflow),
`ifdef COIN_ACCEPTOR_TALLY_EN
        .tally5     (tally5),
        .tally10    (tally10),
`endif
        .fifo_count (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cyc_idx = 0;
        cnt01   = 0;
        cnt10   = 0;
        n_rej   = 0;
        n_adj   = 0;
        first01 = -1;
        prev_in = 2'b00;
        codes.delete();
        idxs.delete();
    endtask

    // one clock; outputs sampled 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_idx++;
        if (in_c == 2'b01) begin
            cnt01++;
            if (first01 < 0) first01 = cyc_idx;
        end
        if (in_c == 2'b10) cnt10++;
        if (in_c != 2'b00) begin
            codes.push_back(in_c);
            idxs.push_back(cyc_idx);
            if (prev_in != 2'b00) n_adj++;
        end
        if (reject) n_rej++;
        prev_in = in_c;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic coin(input bit is10, input int hi, input int lo);
        if (is10) coin10_raw = 1'b1;
        else      coin5_raw  = 1'b1;
        run(hi);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        run(lo);
    endtask

    initial begin : main
        int k;
        rst        = 1'b1;
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        accept_en  = 1'b1;
        clr();
        run(3);
        check("rst_in", in_c, 0);
        check("rst_reject", reject, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fifo_count", fifo_count, 0);
        rst = 1'b0;
        run(20);

        // 1: clean Rs5 pulse
        clr();
        coin5_raw = 1'b1;
        run(20);
        coin5_raw = 1'b0;
        run(20);
        check("t1_latency", first01, 12);
        check("t1_cnt01", cnt01, 1);
        check("t1_cnt10", cnt10, 0);
        check("t1_reject", n_rej, 0);
        check("t1_adjacent", n_adj, 0);

        // 2: short glitches on Rs10
        clr();
        repeat (10) begin
            coin10_raw = 1'b1;
            run(3);
            coin10_raw = 1'b0;
            run(3);
        end
        run(10);
        check("t2_cnt10", cnt10, 0);
        check("t2_cnt01", cnt01, 0);
        check("t2_reject", n_rej, 0);

        // 3: jam
        clr();
        coin5_raw  = 1'b1;
        coin10_raw = 1'b1;
        run(20);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        run(20);
        check("t3_reject", n_rej, 1);
        check("t3_codes", codes.size(), 0);
        check("t3_fifo_count", fifo_count, 0);

        // 4: fill queue with accept_en low, fifth coin overflows
        accept_en = 1'b0;
        clr();
        coin(1'b0, 12, 14);
        coin(1'b1, 12, 14);
        coin(1'b0, 12, 14);
        coin(1'b1, 12, 14);
        coin(1'b0, 12, 14);
        run(5);
        check("t4_fifo_full", fifo_count, 4);
        check("t4_overflow", overflow, 1);
        check("t4_reject", n_rej, 1);
        check("t4_no_emit", codes.size(), 0);
        clr();
        accept_en = 1'b1;
        run(12);
        check("t4_n_codes", codes.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < codes.size()) begin
                check($sformatf("t4_code%0d", i), codes[i], exp_codes[i]);
                check($sformatf("t4_idx%0d", i), idxs[i], 1 + 2 * i);
            end
        end
        check("t4_fifo_empty", fifo_count, 0);
        check("t4_overflow_sticky", overflow, 1);
        check("t4_adjacent", n_adj, 0);

        // 5: reset during EMIT with two coins queued, sensor held high through reset
        accept_en = 1'b0;
        coin(1'b0, 12, 14);
        coin(1'b1, 12, 14);
        check("t5_queued", fifo_count, 2);
        clr();
        accept_en = 1'b1;
        k = 0;
        while (in_c == 2'b00 && k < 30) begin
            cyc();
            k++;
        end
        check("t5_emit_seen", in_c, 1);
        rst       = 1'b1;
        coin5_raw = 1'b1;
        cyc();
        check("t5_in_after_rst", in_c, 0);
        check("t5_fifo_after_rst", fifo_count, 0);
        check("t5_overflow_after_rst", overflow, 0);
        check("t5_reject_after_rst", reject, 0);
        run(2);
        rst = 1'b0;
        clr();
        run(30);
        coin5_raw = 1'b0;
        run(20);
        check("t5_no_coin", codes.size(), 0);
        check("t5_fifo", fifo_count, 0);
        check("t5_reject", n_rej, 0);

        // 6: 3 Rs5 + 2 Rs10 emitted
        clr();
        coin(1'b0, 12, 14);
        coin(1'b0, 12, 14);
        coin(1'b1, 12, 14);
        coin(1'b0, 12, 14);
        coin(1'b1, 12, 14);
        run(5);
        check("t6_cnt01", cnt01, 3);
        check("t6_cnt10", cnt10, 2);
`ifdef COIN_ACCEPTOR_TALLY_EN
        check("t6_tally5", tally5, 3);
        check("t6_tally10", tally10, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
